// File: rtl/dac_stream_buffer.sv
// Primed sample FIFO feeding an AXI-Stream DAC word with underrun repeat and counting.
// Define DAC_RAMP_GEN_EN to add i_test_mode, which streams a per-channel test ramp.
module dac_stream_buffer #(
  parameter int unsigned ZMOD_DATA_SIZE = 14,
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned LANE_SIZE      = 16,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned PRIME_LEVEL    = 8
) (
  input  logic                                i_dac_clock,
  input  logic                                i_reset,
  input  logic                                i_enable,
  input  logic [CHANNELS*ZMOD_DATA_SIZE-1:0]  i_data,
  input  logic                                i_data_valid,
  output logic                                o_data_ready,
  output logic [CHANNELS*LANE_SIZE-1:0]       o_axis_tdata,
  output logic                                o_axis_tvalid,
  input  logic                                i_axis_tready,
`ifdef DAC_RAMP_GEN_EN
  input  logic                                i_test_mode,
`endif
  output logic [$clog2(FIFO_DEPTH):0]         o_fill_level,
  output logic [15:0]                         o_underrun_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = CHANNELS * ZMOD_DATA_SIZE;
  localparam int unsigned OW = CHANNELS * LANE_SIZE;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPrime  = 2'd1;
  localparam logic [1:0] StStream = 2'd2;
  localparam logic [1:0] StFlush  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic          ready_q, ready_d;
  logic          tvalid_q, tvalid_d;
  logic [OW-1:0] tdata_q, tdata_d;
  logic [15:0]   underrun_q, underrun_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] rd_data;
  logic          push, pop, flush, load_en, empty;
`ifdef DAC_RAMP_GEN_EN
  logic [ZMOD_DATA_SIZE-1:0] ramp_q, ramp_d;
`endif

  // Each channel is left-justified in its lane; the low pad bits are zero.
  function automatic logic [OW-1:0] fmt(input logic [DW-1:0] s);
    logic [OW-1:0] w;
    w = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      w[k*LANE_SIZE + LANE_SIZE - ZMOD_DATA_SIZE +: ZMOD_DATA_SIZE] =
          s[k*ZMOD_DATA_SIZE +: ZMOD_DATA_SIZE];
    end
    return w;
  endfunction

  assign push    = i_data_valid && ready_q;
  assign load_en = !tvalid_q || i_axis_tready;
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    underrun_d = underrun_q;
    pop        = 1'b0;
    flush      = 1'b0;
`ifdef DAC_RAMP_GEN_EN
    ramp_d     = ramp_q;
`endif
    case (state_q)
      StIdle: begin
        tvalid_d = 1'b0;
        tdata_d  = '0;
        if (i_enable) begin
          state_d    = StPrime;
          underrun_d = '0;
        end
      end
      StPrime: begin
        if (!i_enable) begin
          state_d = StIdle;
        end else if (count_q >= CW'(PRIME_LEVEL)) begin
          state_d = StStream;
`ifdef DAC_RAMP_GEN_EN
          ramp_d  = '0;
`endif
        end
      end
      StStream: begin
        if (!i_enable) begin
          // A word accepted on this edge must not be offered again while flushing.
          state_d = StFlush;
          if (tvalid_q && i_axis_tready) tvalid_d = 1'b0;
        end else if (load_en) begin
`ifdef DAC_RAMP_GEN_EN
          if (i_test_mode) begin
            tdata_d  = fmt({CHANNELS{ramp_q}});
            tvalid_d = 1'b1;
            ramp_d   = ramp_q + ZMOD_DATA_SIZE'(1);
          end else
`endif
          if (!empty) begin
            pop      = 1'b1;
            tdata_d  = fmt(rd_data);
            tvalid_d = 1'b1;
          end else if (tvalid_q && (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
          end
        end
      end
      default: begin
        if (load_en) begin
          flush    = 1'b1;
          tvalid_d = 1'b0;
          tdata_d  = '0;
          state_d  = StIdle;
        end
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    ready_d = (count_d < CW'(FIFO_DEPTH)) && (state_d != StFlush);
  end

  always_ff @(posedge i_dac_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      underrun_q <= underrun_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

`ifdef DAC_RAMP_GEN_EN
  always_ff @(posedge i_dac_clock or posedge i_reset) begin
    if (i_reset) ramp_q <= '0;
    else         ramp_q <= ramp_d;
  end
`endif

  always_ff @(posedge i_dac_clock) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data_ready     = ready_q;
  assign o_axis_tvalid    = tvalid_q;
  assign o_axis_tdata     = tdata_q;
  assign o_fill_level     = count_q;
  assign o_underrun_count = underrun_q;

endmodule
